// File: rtl/csd_coef_decoder.sv
// rtl/csd_coef_decoder.sv - serial CSD-to-two's-complement coefficient decoder
module csd_coef_decoder #(
  parameter int COEF_WIDTH = 16,
  parameter int TAPS       = 32,
  parameter int ADDR_WIDTH = 5,
  parameter int NZ_WIDTH   = 5
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [2*COEF_WIDTH-1:0] csd_in,
  input  logic [ADDR_WIDTH-1:0]   in_addr,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [COEF_WIDTH-1:0]   coef_out,
  output logic [ADDR_WIDTH-1:0]   coef_addr,
  output logic [NZ_WIDTH-1:0]     nz_count,
  output logic                    coef_err,
  output logic                    coef_valid
);

  localparam int KW = $clog2(COEF_WIDTH);
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] DECODE = 1'b1;

  localparam logic signed [COEF_WIDTH+1:0] SAT_HI = $signed({3'b000, {(COEF_WIDTH-1){1'b1}}});
  localparam logic signed [COEF_WIDTH+1:0] SAT_LO = $signed({3'b111, {(COEF_WIDTH-1){1'b0}}});

  if (TAPS < 1 || TAPS > (1 << ADDR_WIDTH)) begin : g_taps_check
    $error("TAPS does not fit in ADDR_WIDTH");
  end

  logic [0:0]                    state;
  logic [2*COEF_WIDTH-1:0]       csd_q;
  logic [ADDR_WIDTH-1:0]         addr_q;
  logic [KW-1:0]                 k;
  logic signed [COEF_WIDTH+1:0]  acc;
  logic [NZ_WIDTH-1:0]           nz;
  logic                          err;
  logic                          prev_nz;

  logic [1:0]                    code;
  logic                          nonzero;
  logic                          illegal;
  logic signed [COEF_WIDTH+1:0]  acc_next;
  logic [NZ_WIDTH-1:0]           nz_next;
  logic                          err_next;
  logic                          sat_hi;
  logic                          sat_lo;
  logic [COEF_WIDTH-1:0]         coef_final;

  assign in_ready = (state == IDLE);

  // Horner evaluation, MSB digit first; prev_nz tracks digit k+1 for the adjacency rule.
  always_comb begin
    code     = csd_q[{k, 1'b0} +: 2];
    nonzero  = (code == 2'b01) || (code == 2'b11);
    illegal  = (code == 2'b10);
    acc_next = acc <<< 1;
    if (code == 2'b01) begin
      acc_next = acc_next + (COEF_WIDTH+2)'(1);
    end else if (code == 2'b11) begin
      acc_next = acc_next - (COEF_WIDTH+2)'(1);
    end
    nz_next  = nz + NZ_WIDTH'(nonzero);
    err_next = err | illegal | (nonzero & prev_nz);
    sat_hi   = acc_next > SAT_HI;
    sat_lo   = acc_next < SAT_LO;
    if (sat_hi) begin
      coef_final = {1'b0, {(COEF_WIDTH-1){1'b1}}};
    end else if (sat_lo) begin
      coef_final = {1'b1, {(COEF_WIDTH-1){1'b0}}};
    end else begin
      coef_final = acc_next[COEF_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      csd_q      <= '0;
      addr_q     <= '0;
      k          <= '0;
      acc        <= '0;
      nz         <= '0;
      err        <= 1'b0;
      prev_nz    <= 1'b0;
      coef_out   <= '0;
      coef_addr  <= '0;
      nz_count   <= '0;
      coef_err   <= 1'b0;
      coef_valid <= 1'b0;
    end else begin
      coef_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            csd_q   <= csd_in;
            addr_q  <= in_addr;
            acc     <= '0;
            nz      <= '0;
            err     <= 1'b0;
            prev_nz <= 1'b0;
            k       <= KW'(COEF_WIDTH-1);
            state   <= DECODE;
          end
        end
        default: begin
          acc     <= acc_next;
          nz      <= nz_next;
          err     <= err_next;
          prev_nz <= nonzero;
          k       <= k - 1'b1;
          if (k == '0) begin
            coef_out   <= coef_final;
            coef_addr  <= addr_q;
            nz_count   <= nz_next;
            coef_err   <= err_next | sat_hi | sat_lo;
            coef_valid <= 1'b1;
            state      <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
